// File: rtl/k_lsu_master_if.sv
// k_lsu_master_if: CPU request/response and word-memory signals of the LSU master.
interface k_lsu_master_if #(parameter int ADDR_W = 8);
  logic              K_req_valid;
  logic              K_req_write;
  logic [1:0]        K_req_size;
  logic              K_req_signed;
  logic [31:0]       K_req_addr;
  logic [31:0]       K_req_wdata;
  logic              K_req_ready;
  logic              K_resp_valid;
  logic [31:0]       K_resp_rdata;
  logic              K_resp_err;
  logic              K_mem_en;
  logic              K_MemWrite;
  logic [ADDR_W-1:0] K_mem_addr;
  logic [31:0]       K_mem_write_data;
  logic [31:0]       K_mem_read_data;
  modport master (
    input  K_req_valid, K_req_write, K_req_size, K_req_signed, K_req_addr, K_req_wdata, K_mem_read_data,
    output K_req_ready, K_resp_valid, K_resp_rdata, K_resp_err, K_mem_en, K_MemWrite, K_mem_addr, K_mem_write_data
  );
  modport slave (
    output K_req_valid, K_req_write, K_req_size, K_req_signed, K_req_addr, K_req_wdata, K_mem_read_data,
    input  K_req_ready, K_resp_valid, K_resp_rdata, K_resp_err, K_mem_en, K_MemWrite, K_mem_addr, K_mem_write_data
  );
endinterface

// File: rtl/k_lsu_master.sv
// k_lsu_master: byte/half/word load-store unit over a one-cycle-latency word memory.
// Optional K_LSU_MISALIGN_CHECK_EN reports misaligned accesses as errors instead of aligning them.
module k_lsu_master #(
  parameter int ADDR_W = 8
) (
  input logic              K_clk,
  input logic              K_rst_n,
  k_lsu_master_if.master   bus
);
  typedef enum logic [2:0] {IDLE, RD, WT, WR, RESP} state_t;
  state_t            state_q, state_d;
  logic              write_q, signed_q;
  logic [1:0]        size_q, lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              accept, misalign;
  logic [1:0]        size_in, lane_in;
  logic [31:0]       sh_rd, load_val, mask, merged;
  assign accept   = (state_q == IDLE) && bus.K_req_valid;
  assign size_in  = bus.K_req_size[1] ? 2'd2 : bus.K_req_size;
  assign lane_in  = size_in == 2'd2 ? 2'd0 : size_in == 2'd1 ? {bus.K_req_addr[1], 1'b0} : bus.K_req_addr[1:0];
  assign sh_rd    = bus.K_mem_read_data >> {lane_q, 3'b000};
  assign load_val = size_q == 2'd2 ? bus.K_mem_read_data :
                    size_q == 2'd1 ? {{16{signed_q & sh_rd[15]}}, sh_rd[15:0]} :
                                     {{24{signed_q & sh_rd[7]}}, sh_rd[7:0]};
  assign mask     = (size_q == 2'd1 ? 32'h0000_FFFF : 32'h0000_00FF) << {lane_q, 3'b000};
  assign merged   = (bus.K_mem_read_data & ~mask) | (wdata_q & mask);
`ifdef K_LSU_MISALIGN_CHECK_EN
  logic err_q;
  assign misalign = (size_in == 2'd1 && bus.K_req_addr[0]) || (size_in == 2'd2 && bus.K_req_addr[1:0] != 2'd0);
  assign bus.K_resp_err = err_q && (state_q == RESP);
  always_ff @(posedge K_clk or negedge K_rst_n)
    if (!K_rst_n) err_q <= 1'b0;
    else if (accept) err_q <= misalign;
`else
  assign misalign = 1'b0;
  assign bus.K_resp_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.K_req_valid) state_d = misalign ? RESP : (bus.K_req_write && size_in == 2'd2) ? WR : RD;
      RD:      state_d = WT;
      WT:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge K_clk or negedge K_rst_n) begin
    if (!K_rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'd0;
      lane_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= bus.K_req_write;
        signed_q <= bus.K_req_signed;
        size_q   <= size_in;
        lane_q   <= lane_in;
        addr_q   <= bus.K_req_addr[ADDR_W+1:2];
        wdata_q  <= bus.K_req_wdata << {lane_in, 3'b000};
        if (misalign) rdata_q <= '0;
      end
      // Sub-word stores merge into the read word here so WR writes the whole word back.
      if (state_q == WT) begin
        if (write_q) wdata_q <= merged;
        else rdata_q <= load_val;
      end
      if (state_q == WR) rdata_q <= '0;
    end
  end
  assign bus.K_req_ready      = K_rst_n && (state_q == IDLE);
  assign bus.K_resp_valid     = state_q == RESP;
  assign bus.K_resp_rdata     = rdata_q;
  assign bus.K_mem_en         = (state_q == RD) || (state_q == WR);
  assign bus.K_MemWrite       = state_q == WR;
  assign bus.K_mem_addr       = addr_q;
  assign bus.K_mem_write_data = wdata_q;
endmodule

// File: tb/tb_k_lsu_master.sv
// tb_k_lsu_master: directed scoreboard bench for k_lsu_master with a word-memory model.
module tb_k_lsu_master;
  logic K_clk = 1'b0;
  logic K_rst_n = 1'b0;
  always #5 K_clk = ~K_clk;

  k_lsu_master_if #(.ADDR_W(8)) bus();
  k_lsu_master #(.ADDR_W(8)) dut (.K_clk(K_clk), .K_rst_n(K_rst_n), .bus(bus));

  logic [31:0] mem [256];
  always @(posedge K_clk) begin
    if (bus.K_mem_en && !bus.K_MemWrite) bus.K_mem_read_data <= mem[bus.K_mem_addr];
    if (bus.K_mem_en && bus.K_MemWrite) mem[bus.K_mem_addr] <= bus.K_mem_write_data;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [7:0]  addr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, acc = 0, rd_n = 0, wr_n = 0;
  logic [7:0] last_addr = '0;

  always @(posedge K_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input int rdn, input int wrn, input logic [7:0] addr);
    exp_t x;
    x.rdata = rdata; x.err = err; x.lat = lat; x.rd_n = rdn; x.wr_n = wrn; x.addr = addr;
    return x;
  endfunction

  always @(negedge K_clk) begin
    if (bus.K_mem_en) begin
      if (bus.K_MemWrite) wr_n++;
      else rd_n++;
      last_addr = bus.K_mem_addr;
    end
    if (bus.K_resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h expected no response", bus.K_resp_rdata);
      end else begin
        e = q.pop_front();
        chk("rdata", bus.K_resp_rdata, e.rdata);
        chk("err", 32'(bus.K_resp_err), 32'(e.err));
        chk("latency", 32'(cyc - acc + 1), 32'(e.lat));
        chk("rd_cycles", 32'(rd_n), 32'(e.rd_n));
        chk("wr_cycles", 32'(wr_n), 32'(e.wr_n));
        if (e.rd_n + e.wr_n > 0) chk("mem_addr", 32'(last_addr), 32'(e.addr));
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge K_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout: got %0d pending responses expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic op(input logic w, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd, input exp_t x);
    @(negedge K_clk);
    bus.K_req_valid = 1'b1; bus.K_req_write = w; bus.K_req_size = sz;
    bus.K_req_signed = sg; bus.K_req_addr = a; bus.K_req_wdata = wd;
    @(posedge K_clk); #1;
    acc = cyc; rd_n = 0; wr_n = 0;
    q.push_back(x);
    // Busy-state request with scrambled fields must be ignored and not disturb this one.
    bus.K_req_write = ~w; bus.K_req_addr = 32'h0000_0044; bus.K_req_wdata = 32'hFFFF_FFFF;
    @(posedge K_clk); #1;
    bus.K_req_valid = 1'b0;
    wait_done();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.K_req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.K_resp_valid), 32'd0);
    chk({tag, "_rdata"}, bus.K_resp_rdata, 32'd0);
    chk({tag, "_err"}, 32'(bus.K_resp_err), 32'd0);
    chk({tag, "_mem_en"}, 32'(bus.K_mem_en), 32'd0);
    chk({tag, "_memwrite"}, 32'(bus.K_MemWrite), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.K_mem_addr), 32'd0);
    chk({tag, "_wdata"}, bus.K_mem_write_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.K_req_valid = 1'b0; bus.K_req_write = 1'b0; bus.K_req_size = 2'd0;
    bus.K_req_signed = 1'b0; bus.K_req_addr = '0; bus.K_req_wdata = '0;
    repeat (2) @(negedge K_clk);
    chk_zero_outputs("reset");
    @(posedge K_clk); #2;
    K_rst_n = 1'b1;
    @(negedge K_clk);
    chk("ready_after_reset", 32'(bus.K_req_ready), 32'd1);

    op(1'b1, 2'b10, 1'b0, 32'h14, 32'h8899AABB, mk(32'h0, 1'b0, 2, 0, 1, 8'h05));
    op(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, mk(32'h8899AABB, 1'b0, 3, 1, 0, 8'h05));
    op(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, mk(32'hFFFFFF88, 1'b0, 3, 1, 0, 8'h05));
    op(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, mk(32'h000000AA, 1'b0, 3, 1, 0, 8'h05));
    op(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, mk(32'hFFFF8899, 1'b0, 3, 1, 0, 8'h05));
    op(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, mk(32'h0000AABB, 1'b0, 3, 1, 0, 8'h05));
    op(1'b1, 2'b00, 1'b0, 32'h15, 32'h12345677, mk(32'h0, 1'b0, 4, 1, 1, 8'h05));
    chk("mem5_after_sb", mem[5], 32'h889977BB);
    op(1'b1, 2'b01, 1'b0, 32'h14, 32'h0000CAFE, mk(32'h0, 1'b0, 4, 1, 1, 8'h05));
    chk("mem5_after_sh", mem[5], 32'h8899CAFE);
    op(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hDEADBEEF, mk(32'h0, 1'b0, 2, 0, 1, 8'hFF));
    op(1'b0, 2'b11, 1'b0, 32'h3FC, 32'h0, mk(32'hDEADBEEF, 1'b0, 3, 1, 0, 8'hFF));
    op(1'b1, 2'b10, 1'b0, 32'h400, 32'h01020304, mk(32'h0, 1'b0, 2, 0, 1, 8'h00));
    op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, mk(32'h01020304, 1'b0, 3, 1, 0, 8'h00));
`ifdef K_LSU_MISALIGN_CHECK_EN
    op(1'b0, 2'b10, 1'b0, 32'h16, 32'h0, mk(32'h0, 1'b1, 1, 0, 0, 8'h00));
`else
    op(1'b0, 2'b10, 1'b0, 32'h16, 32'h0, mk(32'h8899CAFE, 1'b0, 3, 1, 0, 8'h05));
`endif
    op(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, mk(32'h8899CAFE, 1'b0, 3, 1, 0, 8'h05));

    @(negedge K_clk);
    bus.K_req_valid = 1'b1; bus.K_req_write = 1'b1; bus.K_req_size = 2'b00;
    bus.K_req_signed = 1'b0; bus.K_req_addr = 32'h15; bus.K_req_wdata = 32'h12345677;
    @(posedge K_clk); #1;
    rd_n = 0; wr_n = 0;
    bus.K_req_valid = 1'b0;
    @(posedge K_clk); #1;
    K_rst_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    repeat (3) @(negedge K_clk);
    chk("abort_wr_cycles", 32'(wr_n), 32'd0);
    chk("abort_mem5", mem[5], 32'h8899CAFE);
    @(posedge K_clk); #2;
    K_rst_n = 1'b1;
    @(negedge K_clk);
    chk("ready_after_abort", 32'(bus.K_req_ready), 32'd1);
    op(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, mk(32'h8899CAFE, 1'b0, 3, 1, 0, 8'h05));

    repeat (3) @(negedge K_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
